// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the PLL reset, qualifies the PLL locked flag and
// releases a staged set of active-low domain resets in order 0..NUM_STAGES-1.
// Any lock drop after release has begun pulls every stage back into reset.
// Optional feature macro: PLLSEQ_TIMEOUT_EN. When it is defined, a WAIT_LOCK
// that lasts LOCK_TIMEOUT cycles re-pulses the PLL reset.
module pll_lock_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  ready,
  output logic [7:0]            loss_cnt
);

  // One counter is shared by every state, so it must hold the largest terminal count.
  localparam int M1 = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int M2 = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int CW = $clog2((M1 > M2) ? M1 : M2) + 1;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    lk_meta;
  logic                    lk;
  logic [NUM_STAGES-1:0]   next_mask;
`ifdef PLLSEQ_TIMEOUT_EN
  logic [7:0]              retry_cnt;
`endif

  // Stages release strictly in order, so the release mask is a thermometer code.
  // The next stage is found by shifting in a one.
  assign next_mask = (rst_out_n << 1) | NUM_STAGES'(1);

  // Two-flop synchronizer. pll_locked is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  // Sequencer FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      rst_out_n <= '0;
      ready     <= 1'b0;
      loss_cnt  <= '0;
`ifdef PLLSEQ_TIMEOUT_EN
      retry_cnt <= '0;
`endif
    end else if ((state == RELEASE || state == RUN) && !lk) begin
      // A lock loss after release has begun resets every domain at once.
      state     <= WAIT_LOCK;
      cnt       <= '0;
      rst_out_n <= '0;
      ready     <= 1'b0;
      if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state <= STABLE;
            cnt   <= '0;
          end
`ifdef PLLSEQ_TIMEOUT_EN
          else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            state   <= PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        STABLE: begin
          // A short dropout here is a glitch. Restart qualification without counting a loss.
          if (!lk) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            state     <= RELEASE;
            cnt       <= '0;
            rst_out_n <= NUM_STAGES'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          // With a single stage, every stage is already out on entry. Move on after one cycle.
          if (rst_out_n[NUM_STAGES-1]) begin
            state <= RUN;
            cnt   <= '0;
            ready <= 1'b1;
          end else if (cnt == CW'(STAGE_GAP - 1)) begin
            rst_out_n <= next_mask;
            cnt       <= '0;
            if (next_mask[NUM_STAGES-1]) begin
              state <= RUN;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state     <= PLL_RST;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          rst_out_n <= '0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer. A lock-streak reference model
// works out every output from the sampled lock history.
module tb_pll_lock_sequencer;
  localparam int N = 3, S = 8, G = 4, T = 64, P = 4;
  localparam int RDY_TH = (N == 1) ? S + 2 : 1 + S + (N - 1) * G;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pll_locked = 1'b0;
  logic         pll_rst;
  logic [N-1:0] rst_out_n;
  logic         ready;
  logic [7:0]   loss_cnt;
  logic [N+9:0] obs;

  int checks = 0;
  int errors = 0;

  // Model state:
  //   m_e      - clock edges since reset
  //   m_streak - consecutive synchronized-high samples
  //   m_h1/m_h2 - two-cycle synchronizer delay
  int   m_e, m_streak, m_loss;
  logic m_h1, m_h2;

  pll_lock_sequencer #(
    .NUM_STAGES(N), .STABLE_CYCLES(S), .STAGE_GAP(G),
    .LOCK_TIMEOUT(T), .PLL_RST_CYCLES(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_out_n(rst_out_n), .ready(ready), .loss_cnt(loss_cnt)
  );

  assign obs = {pll_rst, rst_out_n, ready, loss_cnt};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_e = 0; m_streak = 0; m_loss = 0; m_h1 = 1'b0; m_h2 = 1'b0;
  endtask

  // Stage k is out of reset once the streak covers the wait-to-stable edge,
  // then S stable cycles, then k gaps. Lock samples during the PLL reset
  // pulse are ignored.
  function automatic logic [N+9:0] expv();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (m_streak >= 1 + S + k * G);
    return {(m_e < P), r, (m_streak >= RDY_TH), 8'(m_loss)};
  endfunction

  task automatic tick(input logic v);
    logic used;
    pll_locked = v;
    @(posedge clk);
    used = m_h2; m_h2 = m_h1; m_h1 = v;
    m_e++;
    if (m_e > P) begin
      if (used) m_streak++;
      else begin
        if (m_streak >= 1 + S && m_loss < 255) m_loss++;
        m_streak = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic v);
    rst_n = 1'b0;
    pll_locked = v;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== {1'b1, {N{1'b0}}, 1'b0, 8'd0}) begin
      errors++; $display("FAIL reset_values obs=%b exp=%b", obs, {1'b1, {N{1'b0}}, 1'b0, 8'd0});
    end
  endtask

  task automatic test_powerup();
    apply_reset(1'b1);
    for (int i = 0; i < 30; i++) begin
      tick(1'b1);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL powerup cyc=%0d obs=%b exp=%b", i, obs, expv());
      end
    end
    checks++;
    if ({rst_out_n, ready} !== {{N{1'b1}}, 1'b1}) begin
      errors++; $display("FAIL powerup_final obs=%b exp=%b", {rst_out_n, ready}, {{N{1'b1}}, 1'b1});
    end
  endtask

  task automatic test_glitch();
    apply_reset(1'b1);
    for (int i = 0; i < 45; i++) begin
      tick((i == P + 6) ? 1'b0 : 1'b1);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL glitch cyc=%0d obs=%b exp=%b", i, obs, expv());
      end
    end
    checks++;
    if (loss_cnt !== 8'd0) begin
      errors++; $display("FAIL glitch_loss obs=%0d exp=0", loss_cnt);
    end
  endtask

  task automatic test_loss();
    for (int i = 0; i < 50; i++) begin
      tick((i < 20) ? 1'b0 : 1'b1);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL loss cyc=%0d obs=%b exp=%b", i, obs, expv());
      end
    end
    checks++;
    if (loss_cnt !== 8'd1) begin
      errors++; $display("FAIL loss_count obs=%0d exp=1", loss_cnt);
    end
  endtask

  task automatic test_random();
    apply_reset(1'b1);
    for (int r = 0; r < 300; r++) begin
      int hi, lo;
      hi = $urandom_range(25, 1);
      lo = $urandom_range(20, 1);
      for (int i = 0; i < hi + lo; i++) begin
        tick((i < hi) ? 1'b1 : 1'b0);
        checks++;
        if (obs !== expv()) begin
          errors++; $display("FAIL random run=%0d cyc=%0d obs=%b exp=%b", r, i, obs, expv());
        end
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset(1'b1);
    for (int r = 0; r < 260; r++) begin
      for (int i = 0; i < 16; i++) begin
        tick((i < 14) ? 1'b1 : 1'b0);
        checks++;
        if (obs !== expv()) begin
          errors++; $display("FAIL saturation run=%0d cyc=%0d obs=%b exp=%b", r, i, obs, expv());
        end
      end
    end
    checks++;
    if (loss_cnt !== 8'd255) begin
      errors++; $display("FAIL saturation_final obs=%0d exp=255", loss_cnt);
    end
  endtask

  task automatic test_timeout();
    logic e_rst;
    apply_reset(1'b0);
    for (int i = 0; i < 220; i++) begin
      tick(1'b0);
`ifdef PLLSEQ_TIMEOUT_EN
      e_rst = ((m_e % (T + P)) < P);
`else
      e_rst = (m_e < P);
`endif
      checks++;
      if ({pll_rst, rst_out_n, ready} !== {e_rst, {N{1'b0}}, 1'b0}) begin
        errors++; $display("FAIL timeout cyc=%0d obs=%b exp=%b", i, {pll_rst, rst_out_n, ready},
                           {e_rst, {N{1'b0}}, 1'b0});
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    apply_reset(1'b1);
    for (int i = 0; i < 28; i++) begin
      tick((i < 25) ? 1'b1 : 1'b0);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL async_pre cyc=%0d obs=%b exp=%b", i, obs, expv());
      end
    end
    guard = 0;
    while (!(m_streak >= 1 + S + G && m_streak < 1 + S + 2 * G) && guard < 100) begin
      tick(1'b1);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++; $display("FAIL async_wait timed out streak=%0d", m_streak);
    end
    checks++;
    if ({rst_out_n, loss_cnt} !== {3'b011, 8'd1}) begin
      errors++; $display("FAIL async_mid obs=%b exp=%b", {rst_out_n, loss_cnt}, {3'b011, 8'd1});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b1, {N{1'b0}}, 1'b0, 8'd0}) begin
      errors++; $display("FAIL async_reset obs=%b exp=%b", obs, {1'b1, {N{1'b0}}, 1'b0, 8'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_glitch();
    test_loss();
    test_random();
    test_saturation();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
